// File: rtl/umi_regs_arbiter.sv
// umi_regs_arbiter
//   Shares one single-beat, in-order UMI register device between N UMI hosts.
//   Host requests are round-robin arbitrated onto the device request channel.
//   A small FIFO records the owning host of every response-bearing request,
//   and device responses are steered back to the host at the FIFO head.
//
// Ports
//   clk, nreset            clock, synchronous active-low reset
//   host_req_*             N packed host request channels (host i at [i*W+:W])
//   host_req_ready         per-host request ready
//   host_resp_valid        per-host response valid (one-hot or zero)
//   host_resp_*            response payload, broadcast to all hosts
//   host_resp_ready        per-host response ready
//   dev_req_*              request channel to the register device
//   dev_resp_*             response channel from the register device
//   err_unexpected         sticky: device responded with nothing outstanding
//   arb_state              arbiter state (0 = IDLE, 1 = HOLD) for observation
//
// Handshake rule: on every channel a beat transfers on a rising clk edge where
// valid and ready are both 1. A source keeps valid and payload stable until the
// transfer; ready may depend combinationally on valid.
module umi_regs_arbiter #(
  parameter int N      = 4,
  parameter int MAXOUT = 2,
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    host_req_valid,
  input  logic [N*CW-1:0] host_req_cmd,
  input  logic [N*AW-1:0] host_req_dstaddr,
  input  logic [N*AW-1:0] host_req_srcaddr,
  input  logic [N*DW-1:0] host_req_data,
  output logic [N-1:0]    host_req_ready,
  output logic [N-1:0]    host_resp_valid,
  output logic [CW-1:0]   host_resp_cmd,
  output logic [AW-1:0]   host_resp_dstaddr,
  output logic [AW-1:0]   host_resp_srcaddr,
  output logic [DW-1:0]   host_resp_data,
  input  logic [N-1:0]    host_resp_ready,
  output logic            dev_req_valid,
  output logic [CW-1:0]   dev_req_cmd,
  output logic [AW-1:0]   dev_req_dstaddr,
  output logic [AW-1:0]   dev_req_srcaddr,
  output logic [DW-1:0]   dev_req_data,
  input  logic            dev_req_ready,
  input  logic            dev_resp_valid,
  input  logic [CW-1:0]   dev_resp_cmd,
  input  logic [AW-1:0]   dev_resp_dstaddr,
  input  logic [AW-1:0]   dev_resp_srcaddr,
  input  logic [DW-1:0]   dev_resp_data,
  output logic            dev_resp_ready,
  output logic            err_unexpected,
  output logic            arb_state
);

  localparam int GW   = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
  localparam int CNTW = $clog2(MAXOUT + 1);

  // Only read and write produce a response; everything else (posted,
  // atomics, ...) is forwarded fire-and-forget.
  localparam logic [4:0] OP_READ  = 5'h01;
  localparam logic [4:0] OP_WRITE = 5'h03;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   fifo_mem [MAXOUT];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;

  logic [N-1:0]    needs_resp;
  logic [N-1:0]    eligible;
  logic            fifo_full;
  logic            fifo_empty;
  logic [GW-1:0]   grant;
  logic            found;
  logic            req_any;
  logic            req_hs;
  logic            push;
  logic            pop;
  logic [GW-1:0]   head;
  logic [GW-1:0]   grant_next;
  int              idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAXOUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count == CNTW'(MAXOUT));
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign arb_state  = (state == S_HOLD);

  // A full FIFO only holds back requests that would need a FIFO slot.
  always_comb begin
    needs_resp = '0;
    eligible   = '0;
    for (int i = 0; i < N; i++) begin
      needs_resp[i] = (host_req_cmd[i*CW +: 5] == OP_READ) ||
                      (host_req_cmd[i*CW +: 5] == OP_WRITE);
      eligible[i]   = host_req_valid[i] & (~needs_resp[i] | ~fifo_full);
    end
  end

  // Round-robin search starting at rr_ptr. Scanning offsets from high to low
  // lets the smallest offset (closest to rr_ptr) win.
  always_comb begin
    idx   = 0;
    grant = grant_q;
    found = 1'b0;
    if (state == S_IDLE) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N) idx = idx - N;
        if (eligible[idx]) begin
          grant = idx[GW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  assign req_any    = (state == S_HOLD) ? host_req_valid[grant_q] : found;
  assign grant_next = (grant == GW'(N - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    host_req_ready = '0;
    if (nreset && ((state == S_HOLD) || found)) host_req_ready[grant] = dev_req_ready;
  end

  assign dev_req_valid   = nreset & req_any;
  assign dev_req_cmd     = host_req_cmd[int'(grant)*CW +: CW];
  assign dev_req_dstaddr = host_req_dstaddr[int'(grant)*AW +: AW];
  assign dev_req_srcaddr = host_req_srcaddr[int'(grant)*AW +: AW];
  assign dev_req_data    = host_req_data[int'(grant)*DW +: DW];

  assign req_hs = dev_req_valid & dev_req_ready;
  assign push   = req_hs & needs_resp[grant];

  // Response steering: the FIFO head owns the response. With nothing
  // outstanding the response is swallowed and flagged.
  always_comb begin
    host_resp_valid = '0;
    if (nreset && !fifo_empty) host_resp_valid[head] = dev_resp_valid;
  end

  assign dev_resp_ready    = nreset & (fifo_empty | host_resp_ready[head]);
  assign pop               = dev_resp_valid & dev_resp_ready & ~fifo_empty;
  assign host_resp_cmd     = dev_resp_cmd;
  assign host_resp_dstaddr = dev_resp_dstaddr;
  assign host_resp_srcaddr = dev_resp_srcaddr;
  assign host_resp_data    = dev_resp_data;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      grant_q        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_unexpected <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            if (dev_req_ready) begin
              rr_ptr <= grant_next;
            end else begin
              grant_q <= grant;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // A host withdrawing a stalled request forfeits the grant but
          // keeps its round-robin position.
          if (!host_req_valid[grant_q]) begin
            state <= S_IDLE;
          end else if (dev_req_ready) begin
            rr_ptr <= grant_next;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (dev_resp_valid && fifo_empty) err_unexpected <= 1'b1;
    end
  end

  // Owner storage carries no reset; only entries between rd_ptr and wr_ptr
  // are ever read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_umi_regs_arbiter.sv
// Self-checking bench for umi_regs_arbiter (N=4, MAXOUT=2).
module tb_umi_regs_arbiter;

  localparam int N      = 4;
  localparam int MAXOUT = 2;
  localparam int CW     = 32;
  localparam int AW     = 64;
  localparam int DW     = 64;

  localparam logic [4:0] OP_RD   = 5'h01;
  localparam logic [4:0] OP_WR   = 5'h03;
  localparam logic [4:0] OP_PO   = 5'h05;
  localparam logic [4:0] OP_ATOM = 5'h09;

  logic            clk;
  logic            nreset;
  logic [N-1:0]    host_req_valid;
  logic [N*CW-1:0] host_req_cmd;
  logic [N*AW-1:0] host_req_dstaddr;
  logic [N*AW-1:0] host_req_srcaddr;
  logic [N*DW-1:0] host_req_data;
  logic [N-1:0]    host_req_ready;
  logic [N-1:0]    host_resp_valid;
  logic [CW-1:0]   host_resp_cmd;
  logic [AW-1:0]   host_resp_dstaddr;
  logic [AW-1:0]   host_resp_srcaddr;
  logic [DW-1:0]   host_resp_data;
  logic [N-1:0]    host_resp_ready;
  logic            dev_req_valid;
  logic [CW-1:0]   dev_req_cmd;
  logic [AW-1:0]   dev_req_dstaddr;
  logic [AW-1:0]   dev_req_srcaddr;
  logic [DW-1:0]   dev_req_data;
  logic            dev_req_ready;
  logic            dev_resp_valid;
  logic [CW-1:0]   dev_resp_cmd;
  logic [AW-1:0]   dev_resp_dstaddr;
  logic [AW-1:0]   dev_resp_srcaddr;
  logic [DW-1:0]   dev_resp_data;
  logic            dev_resp_ready;
  logic            err_unexpected;
  logic            arb_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard: owners of outstanding response-bearing requests, oldest first.
  logic [2:0] exp_q[$];

  umi_regs_arbiter #(.N(N), .MAXOUT(MAXOUT), .CW(CW), .AW(AW), .DW(DW)) dut (
    .clk(clk), .nreset(nreset),
    .host_req_valid(host_req_valid), .host_req_cmd(host_req_cmd),
    .host_req_dstaddr(host_req_dstaddr), .host_req_srcaddr(host_req_srcaddr),
    .host_req_data(host_req_data), .host_req_ready(host_req_ready),
    .host_resp_valid(host_resp_valid), .host_resp_cmd(host_resp_cmd),
    .host_resp_dstaddr(host_resp_dstaddr), .host_resp_srcaddr(host_resp_srcaddr),
    .host_resp_data(host_resp_data), .host_resp_ready(host_resp_ready),
    .dev_req_valid(dev_req_valid), .dev_req_cmd(dev_req_cmd),
    .dev_req_dstaddr(dev_req_dstaddr), .dev_req_srcaddr(dev_req_srcaddr),
    .dev_req_data(dev_req_data), .dev_req_ready(dev_req_ready),
    .dev_resp_valid(dev_resp_valid), .dev_resp_cmd(dev_resp_cmd),
    .dev_resp_dstaddr(dev_resp_dstaddr), .dev_resp_srcaddr(dev_resp_srcaddr),
    .dev_resp_data(dev_resp_data), .dev_resp_ready(dev_resp_ready),
    .err_unexpected(err_unexpected), .arb_state(arb_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int h, input logic v, input logic [4:0] op,
                         input logic [AW-1:0] addr);
    host_req_valid[h]           = v;
    host_req_cmd[h*CW +: CW]    = {{(CW-5){1'b0}}, op};
    host_req_dstaddr[h*AW +: AW] = addr;
    host_req_srcaddr[h*AW +: AW] = addr ^ 64'hA5A5_0000_0000_0000;
    host_req_data[h*DW +: DW]   = {$urandom, $urandom};
  endtask

  task automatic set_resp(input logic v);
    dev_resp_valid   = v;
    dev_resp_cmd     = $urandom;
    dev_resp_dstaddr = {$urandom, $urandom};
    dev_resp_srcaddr = {$urandom, $urandom};
    dev_resp_data    = {$urandom, $urandom};
  endtask

  task automatic clear_inputs();
    host_req_valid   = '0;
    host_req_cmd     = '0;
    host_req_dstaddr = '0;
    host_req_srcaddr = '0;
    host_req_data    = '0;
    host_resp_ready  = '1;
    dev_req_ready    = 1'b1;
    set_resp(1'b0);
  endtask

  task automatic reset_dut();
    nreset = 1'b0;
    clear_inputs();
    tick();
    tick();
    nreset = 1'b1;
    exp_q.delete();
  endtask

  function automatic bit tb_needs(input int h);
    logic [4:0] op;
    op = host_req_cmd[h*CW +: 5];
    return (op == OP_RD) || (op == OP_WR);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nreset = 1'b0;
    clear_inputs();
    host_req_valid = '1;
    set_resp(1'b1);
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (dev_req_valid !== 1'b0) begin errors++; $display("FAIL rst_dev_req_valid got %0b exp 0", dev_req_valid); end
    checks++;
    if (host_req_ready !== 4'b0) begin errors++; $display("FAIL rst_host_req_ready got %b exp 0000", host_req_ready); end
    checks++;
    if (host_resp_valid !== 4'b0) begin errors++; $display("FAIL rst_host_resp_valid got %b exp 0000", host_resp_valid); end
    checks++;
    if (dev_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_dev_resp_ready got %0b exp 0", dev_resp_ready); end
    checks++;
    if (err_unexpected !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err_unexpected); end
    tick();
    nreset = 1'b1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (dev_resp_ready !== 1'b1) begin errors++; $display("FAIL idle_dev_resp_ready got %0b exp 1", dev_resp_ready); end
    checks++;
    if (arb_state !== 1'b0) begin errors++; $display("FAIL idle_state got %0b exp 0", arb_state); end
    tick();
  endtask

  task automatic test_rr_posted();
    int rr_e;
    logic [N-1:0] exp_rdy;
    reset_dut();
    rr_e = 0;
    for (int c = 0; c < 8; c++) begin
      for (int h = 0; h < N; h++) set_req(h, 1'b1, OP_PO, 64'(h * 256 + c));
      @(negedge clk);
      exp_rdy = '0;
      exp_rdy[rr_e] = 1'b1;
      checks++;
      if (host_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant c%0d got %b exp %b", c, host_req_ready, exp_rdy); end
      checks++;
      if (dev_req_dstaddr !== 64'(rr_e * 256 + c)) begin errors++; $display("FAIL rr_addr c%0d got %0h exp %0h", c, dev_req_dstaddr, rr_e * 256 + c); end
      checks++;
      if (host_resp_valid !== 4'b0) begin errors++; $display("FAIL rr_resp_valid got %b exp 0000", host_resp_valid); end
      rr_e = (rr_e + 1) % N;
      tick();
    end
    host_req_valid = '0;
  endtask

  task automatic test_hold();
    logic [DW-1:0] d;
    reset_dut();
    dev_req_ready = 1'b0;
    set_req(2, 1'b1, OP_RD, 64'h4);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_req(0, 1'b1, OP_PO, 64'h100);
      @(negedge clk);
      checks++;
      if (dev_req_valid !== 1'b1 || dev_req_dstaddr !== 64'h4) begin
        errors++; $display("FAIL hold_addr c%0d got v%0b %0h exp v1 4", c, dev_req_valid, dev_req_dstaddr);
      end
      checks++;
      if (host_req_ready !== 4'b0) begin errors++; $display("FAIL hold_ready c%0d got %b exp 0000", c, host_req_ready); end
      tick();
    end
    checks++;
    if (arb_state !== 1'b1) begin errors++; $display("FAIL hold_state got %0b exp 1", arb_state); end
    dev_req_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b0100) begin errors++; $display("FAIL hold_accept got %b exp 0100", host_req_ready); end
    tick();
    host_req_valid[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b0001 || dev_req_dstaddr !== 64'h100) begin
      errors++; $display("FAIL hold_next got %b %0h exp 0001 100", host_req_ready, dev_req_dstaddr);
    end
    tick();
    host_req_valid[0] = 1'b0;
    set_resp(1'b1);
    d = dev_resp_data;
    @(negedge clk);
    checks++;
    if (host_resp_valid !== 4'b0100) begin errors++; $display("FAIL hold_resp_route got %b exp 0100", host_resp_valid); end
    checks++;
    if (host_resp_data !== d) begin errors++; $display("FAIL hold_resp_data got %0h exp %0h", host_resp_data, d); end
    tick();
    set_resp(1'b0);
  endtask

  task automatic test_fifo_full();
    reset_dut();
    set_req(1, 1'b1, OP_RD, 64'h10);
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b0010) begin errors++; $display("FAIL full_rd1 got %b exp 0010", host_req_ready); end
    tick();
    set_req(1, 1'b1, OP_RD, 64'h18);
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b0010) begin errors++; $display("FAIL full_rd2 got %b exp 0010", host_req_ready); end
    tick();
    set_req(1, 1'b1, OP_RD, 64'h20);
    set_req(3, 1'b1, OP_PO, 64'h300);
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b1000 || dev_req_dstaddr !== 64'h300) begin
      errors++; $display("FAIL full_posted_pass got %b %0h exp 1000 300", host_req_ready, dev_req_dstaddr);
    end
    tick();
    host_req_valid[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b0 || dev_req_valid !== 1'b0) begin
      errors++; $display("FAIL full_stall got %b v%0b exp 0000 v0", host_req_ready, dev_req_valid);
    end
    tick();
    set_resp(1'b1);
    @(negedge clk);
    checks++;
    if (host_resp_valid !== 4'b0010) begin errors++; $display("FAIL full_resp got %b exp 0010", host_resp_valid); end
    checks++;
    if (host_req_ready !== 4'b0) begin errors++; $display("FAIL full_still_blocked got %b exp 0000", host_req_ready); end
    tick();
    set_resp(1'b0);
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b0010 || dev_req_dstaddr !== 64'h20) begin
      errors++; $display("FAIL full_unblock got %b %0h exp 0010 20", host_req_ready, dev_req_dstaddr);
    end
    tick();
    host_req_valid = '0;
  endtask

  task automatic test_resp_order();
    logic [DW-1:0] d;
    reset_dut();
    set_req(0, 1'b1, OP_RD, 64'h40);
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b0001) begin errors++; $display("FAIL ord_rd got %b exp 0001", host_req_ready); end
    tick();
    host_req_valid[0] = 1'b0;
    set_req(3, 1'b1, OP_WR, 64'h48);
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b1000) begin errors++; $display("FAIL ord_wr got %b exp 1000", host_req_ready); end
    tick();
    host_req_valid[3] = 1'b0;
    set_resp(1'b1);
    host_resp_ready = 4'b1110;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (dev_resp_ready !== 1'b0) begin errors++; $display("FAIL ord_backpressure c%0d got %0b exp 0", c, dev_resp_ready); end
      checks++;
      if (host_resp_valid !== 4'b0001) begin errors++; $display("FAIL ord_head c%0d got %b exp 0001", c, host_resp_valid); end
      tick();
    end
    host_resp_ready = 4'b1111;
    @(negedge clk);
    checks++;
    if (dev_resp_ready !== 1'b1) begin errors++; $display("FAIL ord_release got %0b exp 1", dev_resp_ready); end
    tick();
    set_resp(1'b1);
    d = dev_resp_data;
    @(negedge clk);
    checks++;
    if (host_resp_valid !== 4'b1000 || host_resp_data !== d) begin
      errors++; $display("FAIL ord_second got %b %0h exp 1000 %0h", host_resp_valid, host_resp_data, d);
    end
    tick();
    set_resp(1'b0);
    @(negedge clk);
    checks++;
    if (host_resp_valid !== 4'b0) begin errors++; $display("FAIL ord_drained got %b exp 0000", host_resp_valid); end
    tick();
  endtask

  task automatic test_unexpected();
    reset_dut();
    set_resp(1'b1);
    @(negedge clk);
    checks++;
    if (dev_resp_ready !== 1'b1 || host_resp_valid !== 4'b0) begin
      errors++; $display("FAIL unexp_drain got r%0b %b exp r1 0000", dev_resp_ready, host_resp_valid);
    end
    tick();
    set_resp(1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_sticky c%0d got %0b exp 1", c, err_unexpected); end
      tick();
    end
  endtask

  // Entered with err_unexpected still set by the previous scenario.
  task automatic test_reset_mid();
    clear_inputs();
    set_req(0, 1'b1, OP_RD, 64'h50);
    tick();
    host_req_valid[0] = 1'b0;
    set_req(1, 1'b1, OP_RD, 64'h58);
    tick();
    host_req_valid[1] = 1'b0;
    dev_req_ready = 1'b0;
    set_req(2, 1'b1, OP_PO, 64'h60);
    tick();
    checks++;
    if (arb_state !== 1'b1) begin errors++; $display("FAIL mid_held got %0b exp 1", arb_state); end
    nreset = 1'b0;
    set_resp(1'b1);
    @(negedge clk);
    checks++;
    if (dev_req_valid !== 1'b0 || host_req_ready !== 4'b0 || host_resp_valid !== 4'b0 || dev_resp_ready !== 1'b0) begin
      errors++; $display("FAIL mid_outputs_zero got %0b %b %b %0b exp 0 0000 0000 0", dev_req_valid, host_req_ready, host_resp_valid, dev_resp_ready);
    end
    tick();
    nreset = 1'b1;
    set_resp(1'b0);
    host_req_valid[2] = 1'b0;
    dev_req_ready = 1'b1;
    set_req(3, 1'b1, OP_RD, 64'h70);
    @(negedge clk);
    checks++;
    if (host_req_ready !== 4'b1000 || arb_state !== 1'b0) begin
      errors++; $display("FAIL mid_regrant got %b s%0b exp 1000 s0", host_req_ready, arb_state);
    end
    checks++;
    if (err_unexpected !== 1'b0) begin errors++; $display("FAIL mid_err_clear got %0b exp 0", err_unexpected); end
    tick();
    host_req_valid[3] = 1'b0;
    set_resp(1'b1);
    @(negedge clk);
    checks++;
    if (host_resp_valid !== 4'b1000) begin errors++; $display("FAIL mid_fifo_flushed got %b exp 1000", host_resp_valid); end
    tick();
    set_resp(1'b0);
  endtask

  // Random traffic against a transaction-level model: a round-robin order
  // of hosts, a sticky "stalled winner" and a queue of response owners.
  task automatic test_random();
    int rr_m, hold_m, g;
    bit nd, req_acc, resp_acc;
    logic [N-1:0] exp_rdy, exp_rv;
    logic exp_drr;
    logic [4:0] ops[4];
    ops[0] = OP_RD; ops[1] = OP_WR; ops[2] = OP_PO; ops[3] = OP_ATOM;
    reset_dut();
    rr_m = 0;
    hold_m = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int h = 0; h < N; h++)
        if (!host_req_valid[h] && $urandom_range(0, 2) == 0)
          set_req(h, 1'b1, ops[$urandom_range(0, 3)], {$urandom, $urandom});
      dev_req_ready = ($urandom_range(0, 3) != 0);
      host_resp_ready = 4'($urandom_range(0, 15));
      if (!dev_resp_valid && exp_q.size() > 0 && $urandom_range(0, 1) == 1) set_resp(1'b1);
      @(negedge clk);

      g = -1;
      if (hold_m >= 0) g = hold_m;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && host_req_valid[(rr_m + k) % N] &&
              (!tb_needs((rr_m + k) % N) || exp_q.size() < MAXOUT)) g = (rr_m + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = dev_req_ready;
      checks++;
      if (host_req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_req_ready cyc%0d got %b exp %b", cyc, host_req_ready, exp_rdy); end
      checks++;
      if (dev_req_valid !== (g >= 0)) begin errors++; $display("FAIL rnd_dev_valid cyc%0d got %0b exp %0b", cyc, dev_req_valid, g >= 0); end
      if (g >= 0) begin
        checks++;
        if (dev_req_dstaddr !== host_req_dstaddr[g*AW +: AW]) begin
          errors++; $display("FAIL rnd_dev_addr cyc%0d got %0h exp %0h", cyc, dev_req_dstaddr, host_req_dstaddr[g*AW +: AW]);
        end
      end

      exp_rv = '0;
      exp_drr = 1'b1;
      if (exp_q.size() > 0) begin
        exp_drr = host_resp_ready[exp_q[0]];
        if (dev_resp_valid) exp_rv[exp_q[0]] = 1'b1;
      end
      checks++;
      if (host_resp_valid !== exp_rv) begin errors++; $display("FAIL rnd_resp_valid cyc%0d got %b exp %b", cyc, host_resp_valid, exp_rv); end
      checks++;
      if (dev_resp_ready !== exp_drr) begin errors++; $display("FAIL rnd_resp_ready cyc%0d got %0b exp %0b", cyc, dev_resp_ready, exp_drr); end
      if (exp_rv != '0) begin
        checks++;
        if (host_resp_data !== dev_resp_data) begin errors++; $display("FAIL rnd_resp_data cyc%0d got %0h exp %0h", cyc, host_resp_data, dev_resp_data); end
      end

      req_acc  = (g >= 0) && dev_req_ready;
      resp_acc = dev_resp_valid && (exp_q.size() > 0) && exp_drr;
      nd = (g >= 0) ? tb_needs(g) : 1'b0;
      if (resp_acc) void'(exp_q.pop_front());
      if (req_acc && nd) exp_q.push_back(3'(g));
      if (req_acc) begin
        rr_m = (g + 1) % N;
        hold_m = -1;
      end else if (g >= 0) begin
        hold_m = g;
      end
      tick();
      if (req_acc) host_req_valid[g] = 1'b0;
      if (resp_acc) set_resp(1'b0);
    end
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    nreset = 1'b0;
    clear_inputs();
    test_reset();
    test_rr_posted();
    test_hold();
    test_fifo_full();
    test_resp_order();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
